// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory on the CPU load/store port.
// Accepts one request at a time over a valid/ready handshake and waits WAIT_CYCLES
// cycles. It then performs the access and holds the response until the CPU takes it.
//
// Optional feature: define DMEM_BYTE_EN_EN to add req_be, a per-byte store enable.
//
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   req_valid / req_ready  request handshake
//   req_we                 1 = store, 0 = load
//   req_addr               byte address
//   req_wdata              store data
//   req_be                 byte-lane store enable (DMEM_BYTE_EN_EN only)
//   resp_valid/resp_ready  response handshake
//   resp_rdata             load data (0 for stores and errors)
//   resp_err               misaligned or out-of-range access
module data_mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
  input  logic [DATA_W/8-1:0] req_be,
`endif
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [DATA_W-1:0]   mem [Depth];

  // Access operands: latched request, or the live request when WAIT_CYCLES is 0.
  logic                access;
  logic                acc_we;
  logic [31:0]         acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic                acc_err;
  logic [ADDR_W-1:0]   acc_idx;
  logic                req_fire;
  logic                mem_we;

`ifdef DMEM_BYTE_EN_EN
  logic [DATA_W/8-1:0] be_q;
  logic [DATA_W/8-1:0] acc_be;
`endif

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign req_fire   = req_ready & req_valid;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    access    = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
`ifdef DMEM_BYTE_EN_EN
    acc_be    = be_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            access    = 1'b1;
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
`ifdef DMEM_BYTE_EN_EN
            acc_be    = req_be;
`endif
            state_d   = StResp;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) | ((acc_addr >> (ADDR_W + 2)) != 32'd0);
  assign acc_idx = acc_addr[ADDR_W+1:2];
  // Reset gating keeps a zero-wait store presented during reset from committing.
  assign mem_we  = access & acc_we & ~acc_err & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
`ifdef DMEM_BYTE_EN_EN
      be_q    <= '0;
`endif
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req_fire) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
`ifdef DMEM_BYTE_EN_EN
        be_q    <= req_be;
`endif
      end
      if (access) begin
        err_q   <= acc_err;
        rdata_q <= (!acc_we && !acc_err) ? mem[acc_idx] : '0;
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
`ifdef DMEM_BYTE_EN_EN
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (acc_be[b]) mem[acc_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
      end
`else
      mem[acc_idx] <= acc_wdata;
`endif
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned WAIT_CYCLES = 2;
  localparam int unsigned DEPTH       = 2 ** ADDR_W;
  localparam int unsigned BEW         = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
`ifdef DMEM_BYTE_EN_EN
  logic [BEW-1:0]    req_be;
`endif
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  int errors = 0;
  int checks = 0;

  // Reference model: plain word array plus a "contents known" flag per word.
  logic [DATA_W-1:0] mmem   [DEPTH];
  bit                mknown [DEPTH];

  data_mem_responder #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_BYTE_EN_EN
    .req_be    (req_be),
`endif
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_access(input logic we, input logic [31:0] addr,
                              input logic [DATA_W-1:0] wdata, input logic [BEW-1:0] be,
                              output logic [DATA_W-1:0] rdata, output logic err,
                              output logic known);
    int unsigned idx;
    err   = (addr % 4 != 0) || (addr >= 4 * DEPTH);
    idx   = addr / 4;
    rdata = '0;
    known = 1'b1;
    if (!err && we) begin
      if (be == '1) mknown[idx] = 1'b1;
      for (int b = 0; b < int'(BEW); b++)
        if (be[b]) mmem[idx][b*8 +: 8] = wdata[b*8 +: 8];
    end else if (!err) begin
      rdata = mmem[idx];
      known = mknown[idx];
    end
  endtask

  // Called on the negedge after the acceptance edge; n counts edges from acceptance.
  task automatic wait_resp(output int n);
    n = 1;
    while (!resp_valid && n < 64) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [BEW-1:0] be,
                        input int hold);
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
    logic              exp_known;
    int                n;
    model_access(we, addr, wdata, be, exp_rdata, exp_err, exp_known);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
`ifdef DMEM_BYTE_EN_EN
    req_be    = be;
`endif
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(n);
    check({tag, "_lat"}, DATA_W'(n), DATA_W'(WAIT_CYCLES + 1));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    if (exp_known) check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_err"}, DATA_W'(resp_err), DATA_W'(exp_err));
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_done"}, DATA_W'({resp_valid, req_ready}), DATA_W'(2'b01));
  endtask

  initial begin
    logic [DATA_W-1:0] r0;
    logic [31:0]       addr;
    logic [BEW-1:0]    be;
    int                n;
    int                sel;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
`ifdef DMEM_BYTE_EN_EN
    req_be     = '0;
`endif
    resp_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mmem[i]   = '0;
      mknown[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", DATA_W'(req_ready), 1);
    check("rst_resp_valid", DATA_W'(resp_valid), 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", DATA_W'(resp_err), 0);

    // Store then load back.
    do_req("st10", 1'b1, 32'h10, 32'hDEADBEEF, '1, 0);
    do_req("ld10", 1'b0, 32'h10, 32'h0, '1, 1);
    check("ld10_value", resp_rdata, 32'hDEADBEEF);

    // Errors must not disturb a prior store.
    do_req("st0", 1'b1, 32'h0, 32'h12345678, '1, 0);
    do_req("ld13", 1'b0, 32'h13, 32'h0, '1, 0);
    do_req("ld400", 1'b0, 32'h400, 32'h0, '1, 0);
    do_req("st_mis", 1'b1, 32'h2, 32'hFFFFFFFF, '1, 0);
    do_req("st_oor", 1'b1, 32'h800, 32'hFFFFFFFF, '1, 0);
    do_req("ld0", 1'b0, 32'h0, 32'h0, '1, 0);

    // Backpressure in RESP with a second request waiting.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h0;
    wait_resp(n);
    check("bp_lat", DATA_W'(n), DATA_W'(WAIT_CYCLES + 1));
    r0 = resp_rdata;
    check("bp_rdata", r0, mmem[4]);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", DATA_W'(resp_valid), 1);
      check("bp_hold_rdata", resp_rdata, mmem[4]);
      check("bp_hold_err", DATA_W'(resp_err), 0);
      check("bp_hold_ready", DATA_W'(req_ready), 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp_release", DATA_W'({resp_valid, req_ready}), DATA_W'(2'b01));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_second_accepted", DATA_W'(req_ready), 0);
    wait_resp(n);
    check("bp2_lat", DATA_W'(n), DATA_W'(WAIT_CYCLES + 1));
    check("bp2_rdata", resp_rdata, mmem[0]);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset during WAIT of a store: it must not commit.
    do_req("st20", 1'b1, 32'h20, 32'h0, '1, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hCAFEF00D;
`ifdef DMEM_BYTE_EN_EN
    req_be    = '1;
`endif
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_in_wait", DATA_W'({req_ready, resp_valid}), 0);
    reset = 1'b1;
    #1;
    check("mid_rst_req_ready", DATA_W'(req_ready), 1);
    check("mid_rst_resp_valid", DATA_W'(resp_valid), 0);
    check("mid_rst_resp_rdata", resp_rdata, 0);
    check("mid_rst_resp_err", DATA_W'(resp_err), 0);
    @(negedge clk);
    reset = 1'b0;
    do_req("ld20", 1'b0, 32'h20, 32'h0, '1, 0);
    do_req("ld10_after_rst", 1'b0, 32'h10, 32'h0, '1, 0);

`ifdef DMEM_BYTE_EN_EN
    do_req("be_full", 1'b1, 32'h8, 32'hAABBCCDD, 4'b1111, 0);
    do_req("be_part", 1'b1, 32'h8, 32'h11223344, 4'b0101, 0);
    do_req("be_none", 1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, 0);
    do_req("be_ld", 1'b0, 32'h8, 32'h0, 4'b0000, 0);
    check("be_ld_value", resp_rdata, 32'hAA22CC44);
`endif

    // Randomized traffic against the model.
    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 1) addr = ($urandom & ~32'h3) | (32'h1 << (ADDR_W + 2));
      else               addr = 32'($urandom_range(0, 15)) << 2;
`ifdef DMEM_BYTE_EN_EN
      be = BEW'($urandom);
`else
      be = '1;
`endif
      do_req("rnd", 1'($urandom), addr, DATA_W'($urandom), be, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
